// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between the requesting pipeline
// stages and the round-robin arbiter.
//   req         - level-sensitive request vector, one bit per requester
//   grant       - registered one-hot grant, all-zero when idle
//   grant_index - binary index of the current owner, zero when idle
//   grant_valid - high while any grant is active (== |grant)
// Modports: master = requester side, slave = arbiter side.
interface rr_grant_arbiter_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned IW = $clog2(DEPTH);

    logic [DEPTH-1:0] req;
    logic [DEPTH-1:0] grant;
    logic [IW-1:0]    grant_index;
    logic             grant_valid;

    modport master (
        output req,
        input  grant,
        input  grant_index,
        input  grant_valid
    );

    modport slave (
        input  req,
        output grant,
        output grant_index,
        output grant_valid
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter sharing one pipeline resource among
// DEPTH requesters, with burst ownership bounded to MAX_HOLD cycles while
// anyone else is waiting. All outputs are registered; req has no
// combinational path to any output.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - slave side of rr_grant_arbiter_if (req in; grant, grant_index,
//         grant_valid out)
module rr_grant_arbiter #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    rr_grant_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [DEPTH-1:0] grant_q, grant_d;
    logic [IW-1:0]    index_q, index_d;
    logic             valid_q, valid_d;
    logic [DEPTH-1:0] others;
    logic [IW-1:0]    next_start;

    // First set bit of mask scanning upward from start, wrapping modulo DEPTH.
    // DEPTH is a power of two, so the IW-bit add wraps for free.
    function automatic logic [IW-1:0] pick(input logic [IW-1:0] start,
                                           input logic [DEPTH-1:0] mask);
        logic [IW-1:0] idx;
        logic [IW-1:0] res;
        logic          found;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = start + IW'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_d     = hold_q;
        others     = bus.req & ~(DEPTH'(1) << owner_q);
        next_start = owner_q + IW'(1);

        case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    owner_d = pick(ptr_q, bus.req);
                    hold_d  = HOLD_ONE;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Release and hold-limit preemption share one path; a lone
                // requester never reaches it through the hold limit.
                if (!bus.req[owner_q] || ((hold_q == HOLD_MAX) && (|others))) begin
                    ptr_d = next_start;
                    if (|others) begin
                        owner_d = pick(next_start, others);
                        hold_d  = HOLD_ONE;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from next-state so they register with owner.
        grant_d = '0;
        index_d = '0;
        valid_d = 1'b0;
        if (state_d == StBusy) begin
            grant_d = DEPTH'(1) << owner_d;
            index_d = owner_d;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            index_q <= index_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_index = index_q;
    assign bus.grant_valid = valid_q;
endmodule
